i2s_tx_serializer: RTL and testbench
====================================

// Module: i2s_tx_serializer
// PURPOSE
//  I2S transmit serializer: takes filtered 16-bit samples from the biquad path and shifts them
//  to the DAC on sdata. Codec is clock master: bclk/lrclk arrive as inputs and are oversampled
//  on fast clk. Per-channel holding buffers decouple filter output timing from slot timing.
// PARAMETERS
//  DATA_W       16  sample width, sent MSB first, two's complement
//  SYNC_STAGES  2   flip-flop stages on bclk/lrclk before edge detect
// PORTS
//  clk           in   1       system clock; must be >= 8x bclk
//  reset         in   1       synchronous, active-low
//  bclk          in   1       I2S bit clock from codec (async)
//  lrclk         in   1       I2S word select from codec (async); 0 = left, 1 = right
//  sample_in     in   DATA_W  sample to transmit
//  sample_ch     in   1       channel of sample_in; 0 = left, 1 = right
//  sample_valid  in   1       1-cycle write strobe for sample_in into the sample_ch buffer
//  sdata         out  1       I2S serial data to DAC
//  underrun      out  1       1-cycle pulse: slot started with no fresh sample for that channel
// BEHAVIOUR
//  - Reset: sdata=0, underrun=0, hold_l=hold_r=0, fresh_l=fresh_r=0, shift reg 0, state IDLE.
//  - bclk/lrclk go through SYNC_STAGES FFs. bclk_fall = synced bclk 1->0. Edge logic runs only
//    on bclk_fall; lrclk_s is sampled there and compared with the previous sampled value.
//  - Write: sample_valid -> hold_{sample_ch} <= sample_in, fresh_{sample_ch} <= 1.
//  - Load (bclk_fall with lrclk change, c = new lrclk): shreg <= hold_c, fresh_c <= 0.
//    If fresh_c == 0: underrun=1 for one clk and hold_c is resent (last value repeats).
//    If sample_valid writes channel c in the same clk: sample_in is loaded directly, no underrun.
//  - FSM, stepped only on bclk_fall:
//    IDLE  : sdata=0; lrclk change -> load, DELAY. Output stays silent until the first edge.
//    DELAY : one-bit I2S delay; sdata=0; -> SHIFT, bit_cnt=0.
//    SHIFT : sdata=shreg[DATA_W-1], shreg<<=1, bit_cnt++; after bit DATA_W-1 -> PAD.
//    PAD   : sdata=0 for the rest of the slot (any slot width >= DATA_W+1 bclks).
//    Any state: lrclk change -> load, DELAY. This takes priority over all other transitions.
//  - Short slot (lrclk changes in SHIFT): the current word is truncated and the new slot starts
//    cleanly. No flag is raised.
//  - Latency: sdata is registered and updates 1 clk after the internal bclk_fall, which is
//    SYNC_STAGES+1 clk after the pin edge. The DAC samples on bclk rise, half a bclk later.
//  - The MSB appears on the 2nd bclk falling edge after the lrclk transition (standard I2S).
//  - Reset asserted mid-slot: all state is cleared at once. After release, the block waits in
//    IDLE for the next lrclk change and never emits a partial word.
// CONFIGURATION
//  I2S_TX_UNDERRUN_CNT_EN defined: adds output underrun_cnt [7:0].
//    Increments on each underrun pulse, saturates at 8'hFF, cleared only by reset.
//  Undefined: port and counter are absent. The underrun pulse behaves the same either way.
// STRUCTURE
//  i2s_pkg: tx_state_t enum {IDLE, DELAY, SHIFT, PAD}; localparams CH_LEFT=1'b0, CH_RIGHT=1'b1.
//  Sub-module i2s_edge_sync: SYNC_STAGES synchroniser plus registered edge detect, outputs
//  bclk_fall, lrclk_s and lr_change. The same module can be reused on the receive side.
// TESTING
//  1 Write L=16'hA5C3, R=16'h0F01, then run a 32-bclk-slot frame -> left slot sdata bits
//    = 0,1010010111000011,0x15; right = 0,0000111100000001,0x15; underrun never pulses.
//  2 No writes before the second left slot -> underrun pulses once per slot; 16'hA5C3 is resent;
//    with the macro, underrun_cnt reaches 2 after L and R both miss.
//  3 sample_valid (ch=0, 16'h8000) in the same clk as the left load -> 16'h8000 is sent,
//    no underrun.
//  4 lrclk toggles after 10 bits of SHIFT -> the word is truncated; the next bclk_fall gives the
//    delay bit 0, the following one gives the MSB of the new channel.
//  5 Reset low for 3 clk mid-SHIFT -> sdata=0 next clk; after release sdata stays 0 until one
//    full DELAY after the next lrclk edge.
//  6 Force 300 consecutive underruns with the macro defined -> underrun_cnt == 8'hFF and holds.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S serializer blocks.
//   tx_state_t : transmit FSM states
//   CH_LEFT/CH_RIGHT : channel encodings, matching the lrclk level of each slot
//   sat_inc8   : saturating 8-bit increment used by the optional underrun counter
package i2s_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        SHIFT = 2'd2,
        PAD   = 2'd3
    } tx_state_t;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

    function automatic logic [7:0] sat_inc8(input logic [7:0] val);
        logic [7:0] res;
        if (val == 8'hFF) begin
            res = 8'hFF;
        end else begin
            res = val + 8'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/i2s_edge_sync.sv
// Synchroniser and edge detector for the codec-mastered bclk/lrclk pair.
// Ports:
//   clk, reset   system clock, synchronous active-low reset
//   bclk, lrclk  asynchronous pins from the codec
//   bclk_fall    1-clk pulse, registered, one clk after the synced bclk falls
//   lrclk_s      lrclk as sampled on the last bclk falling edge
//   lr_change    1-clk pulse coincident with bclk_fall when lrclk_s changed
// Both pins pass through identical SYNC_STAGES chains so they stay aligned with
// each other; a word-select change made on the same bclk edge is seen together.
module i2s_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic bclk,
    input  logic lrclk,
    output logic bclk_fall,
    output logic lrclk_s,
    output logic lr_change
);

    logic [SYNC_STAGES-1:0] bclk_sync_q, bclk_sync_d;
    logic [SYNC_STAGES-1:0] lr_sync_q, lr_sync_d;
    logic                   bclk_prev_q, bclk_prev_d;
    logic                   fall_q, fall_d;
    logic                   lrclk_s_q, lrclk_s_d;
    logic                   lr_change_q, lr_change_d;
    logic [SYNC_STAGES:0]   bclk_shift_s, lr_shift_s;
    logic                   bclk_synced_s, lr_synced_s, fall_now_s;

    // Next-state: shift the synchroniser chains and detect the bclk fall.
    always_comb begin
        bclk_shift_s  = {bclk_sync_q, bclk};
        lr_shift_s    = {lr_sync_q, lrclk};
        bclk_sync_d   = bclk_shift_s[SYNC_STAGES-1:0];
        lr_sync_d     = lr_shift_s[SYNC_STAGES-1:0];
        bclk_synced_s = bclk_sync_q[SYNC_STAGES-1];
        lr_synced_s   = lr_sync_q[SYNC_STAGES-1];
        fall_now_s    = bclk_prev_q & ~bclk_synced_s;
        bclk_prev_d   = bclk_synced_s;
        fall_d        = fall_now_s;
        if (fall_now_s) begin
            lrclk_s_d   = lr_synced_s;
            lr_change_d = lr_synced_s ^ lrclk_s_q;
        end else begin
            lrclk_s_d   = lrclk_s_q;
            lr_change_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bclk_sync_q <= '0;
            lr_sync_q   <= '0;
            bclk_prev_q <= 1'b0;
            fall_q      <= 1'b0;
            lrclk_s_q   <= 1'b0;
            lr_change_q <= 1'b0;
        end else begin
            bclk_sync_q <= bclk_sync_d;
            lr_sync_q   <= lr_sync_d;
            bclk_prev_q <= bclk_prev_d;
            fall_q      <= fall_d;
            lrclk_s_q   <= lrclk_s_d;
            lr_change_q <= lr_change_d;
        end
    end

    assign bclk_fall = fall_q;
    assign lrclk_s   = lrclk_s_q;
    assign lr_change = lr_change_q;

endmodule

// File: rtl/i2s_tx_serializer.sv
// I2S transmit serializer: per-channel holding buffers feed a shift register that
// drives sdata MSB first, one bit per bclk falling edge, with the standard
// one-bit delay after each lrclk transition.
// Ports:
//   clk, reset            system clock (>= 8x bclk), synchronous active-low reset
//   bclk, lrclk           codec clocks (async); lrclk 0 = left, 1 = right
//   sample_in/ch/valid    1-clk write strobe into the sample_ch holding buffer
//   sdata                 registered serial data to the DAC
//   underrun              1-clk pulse when a slot starts without a fresh sample
//   underrun_cnt          saturating underrun count, only with I2S_TX_UNDERRUN_CNT_EN
module i2s_tx_serializer
    import i2s_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bclk,
    input  logic              lrclk,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_ch,
    input  logic              sample_valid,
`ifdef I2S_TX_UNDERRUN_CNT_EN
    output logic [7:0]        underrun_cnt,
`endif
    output logic              sdata,
    output logic              underrun
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic              bclk_fall_s, lrclk_s, lr_change_s;
    tx_state_t         state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic              fresh_l_q, fresh_l_d, fresh_r_q, fresh_r_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              sdata_q, sdata_d;
    logic              underrun_q, underrun_d;
    logic [DATA_W-1:0] hold_sel_s;
    logic              fresh_sel_s;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [7:0]        ur_cnt_q, ur_cnt_d;
`endif

    i2s_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .reset     (reset),
        .bclk      (bclk),
        .lrclk     (lrclk),
        .bclk_fall (bclk_fall_s),
        .lrclk_s   (lrclk_s),
        .lr_change (lr_change_s)
    );

    // Next-state: buffer writes, slot loads and the bit FSM.
    // bit_cnt counts data bits already placed on sdata. The delay bit is driven
    // on the load edge itself, so DELAY means "delay bit on the wire" and the
    // following fall emits the MSB.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        hold_l_d   = hold_l_q;
        hold_r_d   = hold_r_q;
        fresh_l_d  = fresh_l_q;
        fresh_r_d  = fresh_r_q;
        bit_cnt_d  = bit_cnt_q;
        sdata_d    = sdata_q;
        underrun_d = 1'b0;

        if (lrclk_s == CH_LEFT) begin
            hold_sel_s  = hold_l_q;
            fresh_sel_s = fresh_l_q;
        end else begin
            hold_sel_s  = hold_r_q;
            fresh_sel_s = fresh_r_q;
        end

        if (sample_valid) begin
            if (sample_ch == CH_LEFT) begin
                hold_l_d  = sample_in;
                fresh_l_d = 1'b1;
            end else begin
                hold_r_d  = sample_in;
                fresh_r_d = 1'b1;
            end
        end else begin
            hold_l_d = hold_l_q;
        end

        if (bclk_fall_s) begin
            if (lr_change_s) begin
                // Slot start overrides every state; a same-clk write bypasses the buffer.
                state_d   = DELAY;
                sdata_d   = 1'b0;
                bit_cnt_d = '0;
                if (sample_valid && (sample_ch == lrclk_s)) begin
                    shreg_d = sample_in;
                end else begin
                    shreg_d    = hold_sel_s;
                    underrun_d = ~fresh_sel_s;
                end
                if (lrclk_s == CH_LEFT) begin
                    fresh_l_d = 1'b0;
                end else begin
                    fresh_r_d = 1'b0;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        sdata_d = 1'b0;
                    end
                    DELAY: begin
                        sdata_d   = shreg_q[DATA_W-1];
                        shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
                        bit_cnt_d = CNT_W'(1);
                        state_d   = SHIFT;
                    end
                    SHIFT: begin
                        if (bit_cnt_q == CNT_W'(DATA_W)) begin
                            sdata_d = 1'b0;
                            state_d = PAD;
                        end else begin
                            sdata_d   = shreg_q[DATA_W-1];
                            shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                    PAD: begin
                        sdata_d = 1'b0;
                    end
                    default: begin
                        sdata_d = 1'b0;
                        state_d = IDLE;
                    end
                endcase
            end
        end else begin
            sdata_d = sdata_q;
        end

`ifdef I2S_TX_UNDERRUN_CNT_EN
        if (underrun_q) begin
            ur_cnt_d = sat_inc8(ur_cnt_q);
        end else begin
            ur_cnt_d = ur_cnt_q;
        end
`endif
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            hold_l_q   <= '0;
            hold_r_q   <= '0;
            fresh_l_q  <= 1'b0;
            fresh_r_q  <= 1'b0;
            bit_cnt_q  <= '0;
            sdata_q    <= 1'b0;
            underrun_q <= 1'b0;
`ifdef I2S_TX_UNDERRUN_CNT_EN
            ur_cnt_q   <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            hold_l_q   <= hold_l_d;
            hold_r_q   <= hold_r_d;
            fresh_l_q  <= fresh_l_d;
            fresh_r_q  <= fresh_r_d;
            bit_cnt_q  <= bit_cnt_d;
            sdata_q    <= sdata_d;
            underrun_q <= underrun_d;
`ifdef I2S_TX_UNDERRUN_CNT_EN
            ur_cnt_q   <= ur_cnt_d;
`endif
        end
    end

    assign sdata    = sdata_q;
    assign underrun = underrun_q;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    assign underrun_cnt = ur_cnt_q;
`endif

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Scoreboard bench for i2s_tx_serializer: a small model of the holding buffers
// builds the expected sdata bit stream of each slot into a queue when the slot
// is started; bits are popped and compared half a bclk after each falling edge.
module tb_i2s_tx_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic        bclk;
    logic        lrclk;
    logic [15:0] sample_in;
    logic        sample_ch;
    logic        sample_valid;
    logic        sdata;
    logic        underrun;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [7:0]  underrun_cnt;
`endif

    always #5 clk = ~clk;

    i2s_tx_serializer #(.DATA_W(16), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .sample_in    (sample_in),
        .sample_ch    (sample_ch),
        .sample_valid (sample_valid),
`ifdef I2S_TX_UNDERRUN_CNT_EN
        .underrun_cnt (underrun_cnt),
`endif
        .sdata        (sdata),
        .underrun     (underrun)
    );

    int          err_cnt = 0;
    int          chk_cnt = 0;
    int          ur_seen = 0;
    int          exp_ur  = 0;
    int          m_cnt   = 0;
    logic [15:0] m_hold [2];
    bit          m_fresh [2];
    bit          exp_q [$];

    // Count clocks on which the underrun pulse is high.
    always @(posedge clk) begin
        if (underrun === 1'b1) ur_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // All tasks start and end 2 ns after a rising clk edge.
    task automatic write_sample(input logic ch, input logic [15:0] val);
        sample_ch    = ch;
        sample_in    = val;
        sample_valid = 1'b1;
        #10;
        sample_valid = 1'b0;
        m_hold[ch]   = val;
        m_fresh[ch]  = 1'b1;
    endtask

    // One bclk period; optionally writes lr's buffer in exactly the load clk
    // (pin edge + 2 sync + 1 detect register = 3rd clk edge after the pin).
    task automatic bclk_cycle(input logic lr, input bit wr_same, input logic [15:0] wval);
        bit e;
        bclk  = 1'b0;
        lrclk = lr;
        if (wr_same) begin
            #30;
            sample_ch    = lr;
            sample_in    = wval;
            sample_valid = 1'b1;
            #10;
            sample_valid = 1'b0;
        end else begin
            #40;
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
        chk("sdata", {31'd0, sdata}, {31'd0, e});
        bclk = 1'b1;
        #40;
    endtask

    task automatic reset_mid();
        int n;
        reset = 1'b0;
        #10;
        chk("rst_sdata", {31'd0, sdata}, 32'd0);
        chk("rst_underrun", {31'd0, underrun}, 32'd0);
        #20;
        reset = 1'b1;
        #40;
        m_hold[0]  = 16'h0000;
        m_hold[1]  = 16'h0000;
        m_fresh[0] = 1'b0;
        m_fresh[1] = 1'b0;
        m_cnt      = 0;
        n = exp_q.size();
        exp_q.delete();
        for (int k = 0; k < n; k++) exp_q.push_back(1'b0);
    endtask

    task automatic run_slot(input logic lr, input int ncyc, input bit same_wr,
                            input logic [15:0] wval, input int rst_at);
        logic [15:0] word;
        if (same_wr) begin
            m_hold[lr] = wval;
            word       = wval;
        end else begin
            word = m_hold[lr];
            if (!m_fresh[lr]) begin
                exp_ur++;
                m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            end
        end
        m_fresh[lr] = 1'b0;
        exp_q.delete();
        for (int i = 0; i < ncyc; i++) begin
            if (i >= 1 && i <= 16) exp_q.push_back(word[16-i]);
            else                   exp_q.push_back(1'b0);
        end
        for (int i = 0; i < ncyc; i++) begin
            if (i == rst_at) reset_mid();
            bclk_cycle(lr, same_wr && (i == 0), wval);
        end
        chk("underrun_pulses", ur_seen, exp_ur);
`ifdef I2S_TX_UNDERRUN_CNT_EN
        chk("underrun_cnt", {24'd0, underrun_cnt}, m_cnt);
`endif
    endtask

    initial begin
        reset        = 1'b0;
        bclk         = 1'b1;
        lrclk        = 1'b0;
        sample_in    = 16'h0000;
        sample_ch    = 1'b0;
        sample_valid = 1'b0;
        m_hold[0]    = 16'h0000;
        m_hold[1]    = 16'h0000;
        m_fresh[0]   = 1'b0;
        m_fresh[1]   = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_sdata", {31'd0, sdata}, 32'd0);
        chk("reset_underrun", {31'd0, underrun}, 32'd0);
`ifdef I2S_TX_UNDERRUN_CNT_EN
        chk("reset_cnt", {24'd0, underrun_cnt}, 32'd0);
`endif
        reset = 1'b1;
        #40;

        // Idle: no lrclk change yet, output silent.
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(1'b0);
            bclk_cycle(1'b0, 1'b0, 16'h0000);
        end
        // First edge into right with nothing written: underrun, reset value sent.
        run_slot(1'b1, 32, 1'b0, 16'h0000, -1);

        // Normal frame.
        write_sample(1'b0, 16'hA5C3);
        write_sample(1'b1, 16'h0F01);
        run_slot(1'b0, 32, 1'b0, 16'h0000, -1);
        run_slot(1'b1, 32, 1'b0, 16'h0000, -1);

        // No writes: both slots underrun and resend.
        run_slot(1'b0, 32, 1'b0, 16'h0000, -1);
        run_slot(1'b1, 32, 1'b0, 16'h0000, -1);

        // Write in the load clk goes straight out.
        run_slot(1'b0, 32, 1'b1, 16'h8000, -1);
        write_sample(1'b1, 16'h7FFF);
        run_slot(1'b1, 32, 1'b0, 16'h0000, -1);

        // Short slot: left truncated after 10 data bits.
        write_sample(1'b0, 16'h1234);
        write_sample(1'b1, 16'hFEDC);
        run_slot(1'b0, 11, 1'b0, 16'h0000, -1);
        run_slot(1'b1, 32, 1'b0, 16'h0000, -1);

        // Reset mid-SHIFT of a left slot, then clean restart on the right edge.
        write_sample(1'b0, 16'hBEEF);
        run_slot(1'b0, 32, 1'b0, 16'h0000, 6);
        write_sample(1'b1, 16'h1357);
        run_slot(1'b1, 32, 1'b0, 16'h0000, -1);
        write_sample(1'b0, 16'h2468);
        run_slot(1'b0, 32, 1'b0, 16'h0000, -1);

`ifdef I2S_TX_UNDERRUN_CNT_EN
        // Counter saturation: 300 back-to-back minimum-width slots with no writes.
        for (int s = 0; s < 300; s++) begin
            run_slot((s % 2 == 0) ? 1'b1 : 1'b0, 17, 1'b0, 16'h0000, -1);
        end
        chk("cnt_saturated", {24'd0, underrun_cnt}, 32'h0000_00FF);
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
